// File: rtl/outbuf_writer_pkg.sv
// Shared sizing and state encoding for the output frame-buffer writer.
package outbuf_writer_pkg;
  localparam int DATA_W     = 24;
  localparam int ADDR_W     = 17;
  localparam int WIDTH      = 480;
  localparam int HEIGHT     = 272;
  localparam int DEPTH      = WIDTH * HEIGHT;
  localparam int BORDER_CNT = 2 * WIDTH + 2 * (HEIGHT - 2);
  localparam logic [DATA_W-1:0] BORDER_VAL = '0;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FILL, S_DONE} state_t;
endpackage

// File: rtl/outbuf_border_addr_gen.sv
// Walks the frame border: top row, left/right pairs of middle rows, bottom row.
module outbuf_border_addr_gen
  import outbuf_writer_pkg::*;
#(
  parameter int ADDR_W = outbuf_writer_pkg::ADDR_W,
  parameter int WIDTH  = outbuf_writer_pkg::WIDTH,
  parameter int HEIGHT = outbuf_writer_pkg::HEIGHT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          x_end, full_row;

  assign x_end    = (x == XW'(WIDTH - 1));
  assign full_row = (y == '0) || (y == YW'(HEIGHT - 1));
  assign last     = x_end && (y == YW'(HEIGHT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (start) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (step && !last) begin
      // From any right edge the next border pixel is the following address.
      if (x_end) begin
        x    <= '0;
        y    <= y + YW'(1);
        addr <= addr + ADDR_W'(1);
      end else if (full_row) begin
        x    <= x + XW'(1);
        addr <= addr + ADDR_W'(1);
      end else begin
        x    <= XW'(WIDTH - 1);
        addr <= addr + ADDR_W'(WIDTH - 1);
      end
    end
  end
endmodule

// File: rtl/outbuf_writer.sv
// Writes the interior pixel stream into the frame buffer, then paints the border.
module outbuf_writer
  import outbuf_writer_pkg::*;
#(
  parameter int DATA_W = outbuf_writer_pkg::DATA_W,
  parameter int ADDR_W = outbuf_writer_pkg::ADDR_W,
  parameter int WIDTH  = outbuf_writer_pkg::WIDTH,
  parameter int HEIGHT = outbuf_writer_pkg::HEIGHT,
  parameter logic [DATA_W-1:0] BORDER_VAL = outbuf_writer_pkg::BORDER_VAL
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iValid,
  input  logic [DATA_W-1:0] iPixel,
  output logic              oCs,
  output logic              oWe,
  output logic [ADDR_W-1:0] oAddr,
  output logic [DATA_W-1:0] oDin,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  state_t            state, state_nx;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] int_addr, fill_addr;
  logic              fill_last, start_ok, accept, col_end, last_px, fill_wr, wr, drop;

  assign start_ok = (state == S_IDLE) && iStart;
  assign accept   = (state == S_WRITE) && iValid;
  assign fill_wr  = (state == S_FILL);
  assign wr       = accept || fill_wr;
  // The start cycle swallows a coincident iValid silently.
  assign drop     = iValid && !start_ok && (state != S_WRITE);
  assign col_end  = (col == CW'(WIDTH - 3));
  assign last_px  = col_end && (row == RW'(HEIGHT - 3));
  assign oBusy    = (state == S_WRITE) || (state == S_FILL);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (iStart) state_nx = S_WRITE;
      S_WRITE: if (accept && last_px) state_nx = S_FILL;
      S_FILL:  if (fill_last) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Interior address walks incrementally; leaving a row skips the right and left border.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      col      <= '0;
      row      <= '0;
      int_addr <= '0;
    end else if (start_ok) begin
      col      <= '0;
      row      <= '0;
      int_addr <= ADDR_W'(WIDTH + 1);
    end else if (accept) begin
      if (col_end) begin
        col      <= '0;
        row      <= row + RW'(1);
        int_addr <= int_addr + ADDR_W'(3);
      end else begin
        col      <= col + CW'(1);
        int_addr <= int_addr + ADDR_W'(1);
      end
    end
  end

  outbuf_border_addr_gen #(
    .ADDR_W (ADDR_W),
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_border (
    .clk   (iClk),
    .rst_n (iRst),
    .start (accept && last_px),
    .step  (fill_wr),
    .addr  (fill_addr),
    .last  (fill_last)
  );

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      oCs   <= 1'b0;
      oWe   <= 1'b0;
      oAddr <= '0;
      oDin  <= '0;
      oDone <= 1'b0;
      oErr  <= 1'b0;
    end else begin
      oCs   <= wr;
      oWe   <= wr;
      if (accept) begin
        oAddr <= int_addr;
        oDin  <= iPixel;
      end else if (fill_wr) begin
        oAddr <= fill_addr;
        oDin  <= BORDER_VAL;
      end
      oDone <= (state == S_DONE);
      if (start_ok)  oErr <= 1'b0;
      else if (drop) oErr <= 1'b1;
    end
  end
endmodule
